pool_engine: RTL and testbench

//  Parametrised pooling engine, next generation of the CIFAR max-pooling stage. Reads a

---
 rtl/pool_engine.sv | 334 +++++++++++++++++++++++++++++++++
 tb/tb_pool_engine.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pool_engine.sv
// pool_engine: k x k window pooling (max, or average when POOL_AVG_EN is defined) over a
// channel-major feature map held in a single-port SRAM with 1-cycle read latency.
module pool_engine #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 13,
    parameter int MAX_K  = 4,
    parameter int SIGNED = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] cfg_rows,
    input  logic [ADDR_W-1:0] cfg_cols,
    input  logic [ADDR_W-1:0] cfg_ch,
    input  logic [3:0]        cfg_k,
    input  logic [3:0]        cfg_stride,
    input  logic              cfg_avg,
    input  logic [ADDR_W-1:0] cfg_in,
    input  logic [ADDR_W-1:0] cfg_out,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              done,
    output logic              err
);
    // state | meaning
    // IDLE  | waiting for start, config capture
    // CHECK | validate captured config, precompute row/channel strides
    // RD    | issue k*k window reads, fold the sample returned from the previous read
    // LAST  | fold final sample of the window
    // WR    | write pooled result, step to next window
    // FIN   | done pulse (err if config was rejected)
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CHECK = 3'd1;
    localparam logic [2:0] S_RD    = 3'd2;
    localparam logic [2:0] S_LAST  = 3'd3;
    localparam logic [2:0] S_WR    = 3'd4;
    localparam logic [2:0] S_FIN   = 3'd5;

    localparam int CNT_W = $clog2(MAX_K * MAX_K + 1);
    localparam int EW    = ADDR_W + 2;
`ifdef POOL_AVG_EN
    localparam int ACC_W = DATA_W + 2 * $clog2(MAX_K);
`else
    localparam int ACC_W = DATA_W;
`endif

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] rows_q, rows_d, cols_q, cols_d, ch_n_q, ch_n_d;
    logic [3:0]        k_q, k_d, s_q, s_d;
    logic [ADDR_W-1:0] sc_q, sc_d, rc_q, rc_d;
    logic [ADDR_W-1:0] c0_q, c0_d, r0_q, r0_d, ch_q, ch_d;
    logic [ADDR_W-1:0] win_q, win_d, row_base_q, row_base_d, ch_base_q, ch_base_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d, row_ptr_q, row_ptr_d, out_addr_q, out_addr_d;
    logic [3:0]        kc_q, kc_d;
    logic [CNT_W-1:0]  samp_q, samp_d;
    logic              rv_q, rv_d, fresh_q, fresh_d, err_q, err_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
`ifdef POOL_AVG_EN
    logic              avg_q, avg_d;
`else
    logic              unused_avg;
    assign unused_avg = cfg_avg;
`endif

    logic [ADDR_W-1:0] k_ext, s_ext, nxt_win;
    logic [7:0]        kk_full;
    logic [CNT_W-1:0]  kk_m1;
    logic              col_fit, row_fit, last_ch, cfg_bad, fold;
    logic [ACC_W-1:0]  samp_ext;
    logic              samp_gt;
    logic [DATA_W-1:0] result;

    assign k_ext   = ADDR_W'(k_q);
    assign s_ext   = ADDR_W'(s_q);
    assign kk_full = {4'd0, k_q} * {4'd0, k_q};
    assign kk_m1   = CNT_W'(kk_full - 8'd1);
    // Next window must still fit entirely inside the map; extra bits keep the sum from wrapping.
    assign col_fit = ({2'b00, c0_q} + EW'(s_q) + EW'(k_q)) <= {2'b00, cols_q};
    assign row_fit = ({2'b00, r0_q} + EW'(s_q) + EW'(k_q)) <= {2'b00, rows_q};
    assign last_ch = (ch_q == ch_n_q - ADDR_W'(1));
    assign fold    = ((state_q == S_RD) && rv_q) || (state_q == S_LAST);

    always_comb begin
        cfg_bad = (k_q == 4'd0) || (k_q > 4'(MAX_K)) || (s_q == 4'd0) ||
                  (ch_n_q == '0) || (k_ext > rows_q) || (k_ext > cols_q);
`ifdef POOL_AVG_EN
        if (avg_q && !(k_q inside {4'd1, 4'd2, 4'd4, 4'd8})) begin
            cfg_bad = 1'b1;
        end
`endif
    end

    always_comb begin
        if (SIGNED != 0) begin
            samp_ext = ACC_W'($signed(mem_rdata));
            samp_gt  = $signed(mem_rdata) > $signed(acc_q[DATA_W-1:0]);
        end else begin
            samp_ext = ACC_W'(mem_rdata);
            samp_gt  = mem_rdata > acc_q[DATA_W-1:0];
        end
    end

`ifdef POOL_AVG_EN
    logic [2:0]              avg_sh;
    logic signed [ACC_W-1:0] shr_s;
    logic [ACC_W-1:0]        shr_u;

    always_comb begin
        case (k_q)
            4'd2:    avg_sh = 3'd2;
            4'd4:    avg_sh = 3'd4;
            4'd8:    avg_sh = 3'd6;
            default: avg_sh = 3'd0;
        endcase
        shr_s  = $signed(acc_q) >>> avg_sh;
        shr_u  = acc_q >> avg_sh;
        result = acc_q[DATA_W-1:0];
        if (avg_q) begin
            result = (SIGNED != 0) ? shr_s[DATA_W-1:0] : shr_u[DATA_W-1:0];
        end
    end
`else
    assign result = acc_q[DATA_W-1:0];
`endif

    always_comb begin
        state_d    = state_q;
        rows_d     = rows_q;
        cols_d     = cols_q;
        ch_n_d     = ch_n_q;
        k_d        = k_q;
        s_d        = s_q;
        sc_d       = sc_q;
        rc_d       = rc_q;
        c0_d       = c0_q;
        r0_d       = r0_q;
        ch_d       = ch_q;
        win_d      = win_q;
        row_base_d = row_base_q;
        ch_base_d  = ch_base_q;
        rd_addr_d  = rd_addr_q;
        row_ptr_d  = row_ptr_q;
        out_addr_d = out_addr_q;
        kc_d       = kc_q;
        samp_d     = samp_q;
        fresh_d    = fresh_q;
        err_d      = err_q;
        acc_d      = acc_q;
        nxt_win    = win_q;
        rv_d       = (state_q == S_RD);
`ifdef POOL_AVG_EN
        avg_d      = avg_q;
`endif

        // First sample of a window loads the accumulator outright.
        if (fold) begin
            fresh_d = 1'b0;
`ifdef POOL_AVG_EN
            if (avg_q && !fresh_q) begin
                acc_d = acc_q + samp_ext;
            end else if (avg_q || fresh_q || samp_gt) begin
                acc_d = samp_ext;
            end
`else
            if (fresh_q || samp_gt) begin
                acc_d = samp_ext;
            end
`endif
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    rows_d     = cfg_rows;
                    cols_d     = cfg_cols;
                    ch_n_d     = cfg_ch;
                    k_d        = cfg_k;
                    s_d        = cfg_stride;
                    out_addr_d = cfg_out;
                    win_d      = cfg_in;
                    row_base_d = cfg_in;
                    ch_base_d  = cfg_in;
                    rd_addr_d  = cfg_in;
                    row_ptr_d  = cfg_in;
                    c0_d       = '0;
                    r0_d       = '0;
                    ch_d       = '0;
                    err_d      = 1'b0;
`ifdef POOL_AVG_EN
                    avg_d      = cfg_avg;
`endif
                    state_d    = S_CHECK;
                end
            end
            S_CHECK: begin
                sc_d = s_ext * cols_q;
                rc_d = rows_q * cols_q;
                if (cfg_bad) begin
                    err_d   = 1'b1;
                    state_d = S_FIN;
                end else begin
                    samp_d  = kk_m1;
                    kc_d    = k_q - 4'd1;
                    fresh_d = 1'b1;
                    state_d = S_RD;
                end
            end
            S_RD: begin
                if (samp_q == '0) begin
                    state_d = S_LAST;
                end else begin
                    samp_d = samp_q - CNT_W'(1);
                    if (kc_q == 4'd0) begin
                        kc_d      = k_q - 4'd1;
                        row_ptr_d = row_ptr_q + cols_q;
                        rd_addr_d = row_ptr_q + cols_q;
                    end else begin
                        kc_d      = kc_q - 4'd1;
                        rd_addr_d = rd_addr_q + ADDR_W'(1);
                    end
                end
            end
            S_LAST: state_d = S_WR;
            S_WR: begin
                out_addr_d = out_addr_q + ADDR_W'(1);
                samp_d     = kk_m1;
                kc_d       = k_q - 4'd1;
                fresh_d    = 1'b1;
                state_d    = S_RD;
                if (col_fit) begin
                    c0_d    = c0_q + s_ext;
                    nxt_win = win_q + s_ext;
                end else if (row_fit) begin
                    c0_d       = '0;
                    r0_d       = r0_q + s_ext;
                    nxt_win    = row_base_q + sc_q;
                    row_base_d = nxt_win;
                end else if (!last_ch) begin
                    c0_d       = '0;
                    r0_d       = '0;
                    ch_d       = ch_q + ADDR_W'(1);
                    nxt_win    = ch_base_q + rc_q;
                    ch_base_d  = nxt_win;
                    row_base_d = nxt_win;
                end else begin
                    state_d = S_FIN;
                end
                win_d     = nxt_win;
                rd_addr_d = nxt_win;
                row_ptr_d = nxt_win;
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            rows_q     <= '0;
            cols_q     <= '0;
            ch_n_q     <= '0;
            k_q        <= '0;
            s_q        <= '0;
            sc_q       <= '0;
            rc_q       <= '0;
            c0_q       <= '0;
            r0_q       <= '0;
            ch_q       <= '0;
            win_q      <= '0;
            row_base_q <= '0;
            ch_base_q  <= '0;
            rd_addr_q  <= '0;
            row_ptr_q  <= '0;
            out_addr_q <= '0;
            kc_q       <= '0;
            samp_q     <= '0;
            rv_q       <= 1'b0;
            fresh_q    <= 1'b0;
            err_q      <= 1'b0;
            acc_q      <= '0;
`ifdef POOL_AVG_EN
            avg_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            rows_q     <= rows_d;
            cols_q     <= cols_d;
            ch_n_q     <= ch_n_d;
            k_q        <= k_d;
            s_q        <= s_d;
            sc_q       <= sc_d;
            rc_q       <= rc_d;
            c0_q       <= c0_d;
            r0_q       <= r0_d;
            ch_q       <= ch_d;
            win_q      <= win_d;
            row_base_q <= row_base_d;
            ch_base_q  <= ch_base_d;
            rd_addr_q  <= rd_addr_d;
            row_ptr_q  <= row_ptr_d;
            out_addr_q <= out_addr_d;
            kc_q       <= kc_d;
            samp_q     <= samp_d;
            rv_q       <= rv_d;
            fresh_q    <= fresh_d;
            err_q      <= err_d;
            acc_q      <= acc_d;
`ifdef POOL_AVG_EN
            avg_q      <= avg_d;
`endif
        end
    end

    // Outputs decode straight from state so an async reset clears them immediately.
    always_comb begin
        busy      = (state_q inside {S_CHECK, S_RD, S_LAST, S_WR});
        done      = (state_q == S_FIN);
        err       = done && err_q;
        mem_we    = (state_q == S_WR);
        mem_addr  = '0;
        mem_wdata = '0;
        if (state_q == S_RD) begin
            mem_addr = rd_addr_q;
        end else if (state_q == S_WR) begin
            mem_addr  = out_addr_q;
            mem_wdata = result;
        end
    end

endmodule

// File: tb/tb_pool_engine.sv
// Scoreboard bench for pool_engine: an unsigned and a signed instance run the same jobs,
// a loop-based reference model queues expected writes and done timing per instance.
module tb_pool_engine;
    localparam int DW  = 8;
    localparam int AW  = 13;
    localparam int MK  = 4;
    localparam int MSZ = 1 << AW;

    typedef struct { int addr; int data; } wr_t;
    typedef struct { int cycles; int err; } dn_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          start, cfg_avg;
    logic [AW-1:0] cfg_rows, cfg_cols, cfg_ch, cfg_in, cfg_out;
    logic [3:0]    cfg_k, cfg_stride;
    logic [AW-1:0] addr0, addr1;
    logic          we0, we1, busy0, busy1, done0, done1, err0, err1;
    logic [DW-1:0] wd0, wd1, rd0, rd1;
    logic [DW-1:0] mem0 [MSZ];
    logic [DW-1:0] mem1 [MSZ];

    wr_t wq0[$], wq1[$];
    dn_t dq0[$], dq1[$];
    int  vectors = 0, miscompares = 0;
    int  cyc = 0, start_cyc = 0, wcnt0 = 0, wcnt1 = 0;

    pool_engine #(.DATA_W(DW), .ADDR_W(AW), .MAX_K(MK), .SIGNED(0)) u_dut_u (
        .clk(clk), .rst(rst), .start(start), .cfg_rows(cfg_rows), .cfg_cols(cfg_cols),
        .cfg_ch(cfg_ch), .cfg_k(cfg_k), .cfg_stride(cfg_stride), .cfg_avg(cfg_avg),
        .cfg_in(cfg_in), .cfg_out(cfg_out), .mem_addr(addr0), .mem_we(we0), .mem_wdata(wd0),
        .mem_rdata(rd0), .busy(busy0), .done(done0), .err(err0));

    pool_engine #(.DATA_W(DW), .ADDR_W(AW), .MAX_K(MK), .SIGNED(1)) u_dut_s (
        .clk(clk), .rst(rst), .start(start), .cfg_rows(cfg_rows), .cfg_cols(cfg_cols),
        .cfg_ch(cfg_ch), .cfg_k(cfg_k), .cfg_stride(cfg_stride), .cfg_avg(cfg_avg),
        .cfg_in(cfg_in), .cfg_out(cfg_out), .mem_addr(addr1), .mem_we(we1), .mem_wdata(wd1),
        .mem_rdata(rd1), .busy(busy1), .done(done1), .err(err1));

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (we0) mem0[addr0] <= wd0;
        if (we1) mem1[addr1] <= wd1;
        rd0 <= mem0[addr0];
        rd1 <= mem1[addr1];
    end

    task automatic check(string name, int act, int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic fail(string name, string what);
        vectors++;
        miscompares++;
        $display("FAIL %s: got %s, required none", name, what);
    endtask

    function automatic int pix(int g, int a);
        byte sb;
        logic [7:0] b;
        b  = (g == 0) ? mem0[a % MSZ] : mem1[a % MSZ];
        sb = b;
        return (g == 0) ? int'(b) : int'(sb);
    endfunction

    // Reference: direct loops over channel / output row / output col / kernel position.
    task automatic model(int g, int r, int c, int n, int k, int s, int avg, int inb, int outb);
        int orr, oc, o, v, best, sum, res;
        bit ill;
        dn_t e;
        wr_t w;
        ill = (k == 0) || (k > MK) || (s == 0) || (n == 0) || (k > r) || (k > c);
`ifdef POOL_AVG_EN
        if (avg != 0 && !(k == 1 || k == 2 || k == 4 || k == 8)) ill = 1'b1;
`endif
        if (ill) begin
            e.cycles = 2;
            e.err    = 1;
        end else begin
            orr = (r - k) / s + 1;
            oc  = (c - k) / s + 1;
            o   = 0;
            for (int ch = 0; ch < n; ch++)
                for (int orow = 0; orow < orr; orow++)
                    for (int ocol = 0; ocol < oc; ocol++) begin
                        best = 0;
                        sum  = 0;
                        for (int i = 0; i < k; i++)
                            for (int j = 0; j < k; j++) begin
                                v = pix(g, inb + (ch * r + orow * s + i) * c + ocol * s + j);
                                sum += v;
                                if ((i == 0 && j == 0) || v > best) best = v;
                            end
                        res = best;
`ifdef POOL_AVG_EN
                        if (avg != 0) begin
                            res = sum / (k * k);
                            if ((sum % (k * k)) != 0 && sum < 0) res = res - 1;
                        end
`endif
                        w.addr = (outb + o) % MSZ;
                        w.data = res & 255;
                        if (g == 0) wq0.push_back(w); else wq1.push_back(w);
                        o++;
                    end
            e.cycles = 2 + n * orr * oc * (k * k + 2);
            e.err    = 0;
        end
        if (g == 0) dq0.push_back(e); else dq1.push_back(e);
    endtask

    task automatic mon(int g, logic we, logic [AW-1:0] a, logic [DW-1:0] d,
                       logic dn, logic er, logic bz);
        wr_t w;
        dn_t e;
        int left;
        if (we) begin
            if (g == 0) wcnt0++; else wcnt1++;
            if ((g == 0 ? wq0.size() : wq1.size()) == 0) begin
                fail($sformatf("unexpected_write%0d", g), $sformatf("write @%0d", a));
            end else begin
                if (g == 0) w = wq0.pop_front(); else w = wq1.pop_front();
                check($sformatf("wr_addr%0d", g), int'(a), w.addr);
                check($sformatf("wr_data%0d", g), int'(d), w.data);
            end
        end
        if (dn) begin
            left = (g == 0) ? wq0.size() : wq1.size();
            if ((g == 0 ? dq0.size() : dq1.size()) == 0) begin
                fail($sformatf("unexpected_done%0d", g), "done pulse");
            end else begin
                if (g == 0) e = dq0.pop_front(); else e = dq1.pop_front();
                check($sformatf("done_cycle%0d", g), cyc - start_cyc, e.cycles);
                check($sformatf("err%0d", g), int'(er), e.err);
                check($sformatf("writes_missing%0d", g), left, 0);
                check($sformatf("busy_at_done%0d", g), int'(bz), 0);
            end
        end else if (er) begin
            fail($sformatf("err_without_done%0d", g), "err pulse");
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            mon(0, we0, addr0, wd0, done0, err0, busy0);
            mon(1, we1, addr1, wd1, done1, err1, busy1);
        end
    end

    task automatic set_cfg(int r, int c, int n, int k, int s, int avg, int inb, int outb);
        cfg_rows   = AW'(r);
        cfg_cols   = AW'(c);
        cfg_ch     = AW'(n);
        cfg_k      = 4'(k);
        cfg_stride = 4'(s);
        cfg_avg    = (avg != 0);
        cfg_in     = AW'(inb);
        cfg_out    = AW'(outb);
    endtask

    task automatic scramble_cfg();
        set_cfg($urandom_range(0, 8191), $urandom_range(0, 8191), $urandom_range(0, 8191),
                $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 1),
                $urandom_range(0, 8191), $urandom_range(0, 8191));
    endtask

    task automatic put(int a, int v);
        mem0[a % MSZ] = DW'(v);
        mem1[a % MSZ] = DW'(v);
    endtask

    // Called 1 time unit after a rising edge.
    task automatic run_job(int r, int c, int n, int k, int s, int avg, int inb, int outb);
        int budget;
        model(0, r, c, n, k, s, avg, inb, outb);
        model(1, r, c, n, k, s, avg, inb, outb);
        wcnt0 = 0;
        wcnt1 = 0;
        set_cfg(r, c, n, k, s, avg, inb, outb);
        start     = 1'b1;
        start_cyc = cyc;
        @(posedge clk); #1;
        check("busy_after_start0", int'(busy0), 1);
        check("busy_after_start1", int'(busy1), 1);
        // A second start and changed cfg while busy must not disturb the job.
        scramble_cfg();
        @(posedge clk); #1;
        start  = 1'b0;
        budget = 0;
        while ((dq0.size() != 0 || dq1.size() != 0) && budget < 4000) begin
            @(posedge clk);
            budget++;
        end
        if (budget >= 4000) begin
            fail("job_timeout", "no done within 4000 cycles");
            wq0.delete(); wq1.delete(); dq0.delete(); dq1.delete();
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic load_ramp(int inb);
        for (int i = 0; i < 16; i++) put(inb + i, i);
    endtask

    task automatic check_t1(string tag, int outb, int e0, int e1, int e2, int e3);
        int ex[4];
        ex = '{e0, e1, e2, e3};
        for (int i = 0; i < 4; i++) begin
            check($sformatf("%s_u[%0d]", tag, i), int'(mem0[outb + i]), ex[i]);
            check($sformatf("%s_s[%0d]", tag, i), int'(mem1[outb + i]), ex[i]);
        end
    endtask

    initial begin
        int r, c, n, k, s, avg, inb, outb, b;
        int m2[9];
        rst   = 1'b0;
        start = 1'b0;
        set_cfg(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy0", int'(busy0), 0);
        check("rst_done1", int'(done1), 0);
        check("rst_we0", int'(we0), 0);
        check("rst_addr1", int'(addr1), 0);
        #2 rst = 1'b1;
        @(posedge clk); #1;

        // 4x4 ramp, k=2 s=2
        load_ramp(0);
        run_job(4, 4, 1, 2, 2, 0, 0, 100);
        check_t1("t1", 100, 5, 7, 13, 15);

        // overlapping windows
        m2 = '{9, 1, 2, 3, 4, 8, 7, 6, 5};
        for (int i = 0; i < 9; i++) put(200 + i, m2[i]);
        run_job(3, 3, 1, 2, 1, 0, 200, 260);
        check_t1("t2", 260, 9, 8, 7, 8);

        // negative pixels: ch0 {-3,-1,-7,-2}, ch1 all 0xFF
        put(300, 8'hFD); put(301, 8'hFF); put(302, 8'hF9); put(303, 8'hFE);
        for (int i = 4; i < 8; i++) put(300 + i, 8'hFF);
        run_job(2, 2, 2, 2, 2, 0, 300, 400);
        check("t3_out0_s", int'(mem1[400]), 255);
        check("t3_out1_s", int'(mem1[401]), 255);

        // illegal configs
        run_job(4, 4, 1, 0, 2, 0, 0, 500);
        run_job(4, 4, 1, 5, 2, 0, 0, 500);
        run_job(4, 4, 1, 2, 0, 0, 0, 500);

        // reset in the middle of the second window
        for (int i = 0; i < 4; i++) put(600 + i, 0);
        model(0, 4, 4, 1, 2, 2, 0, 0, 600);
        model(1, 4, 4, 1, 2, 2, 0, 0, 600);
        wcnt0 = 0;
        wcnt1 = 0;
        set_cfg(4, 4, 1, 2, 2, 0, 0, 600);
        start     = 1'b1;
        start_cyc = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        b = 0;
        while (wcnt0 < 1 && b < 100) begin
            @(posedge clk);
            b++;
        end
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        check("arst_busy0", int'(busy0), 0);
        check("arst_busy1", int'(busy1), 0);
        check("arst_addr0", int'(addr0), 0);
        check("arst_we1", int'(we1), 0);
        check("arst_done0", int'(done0), 0);
        check("writes_before_rst0", wcnt0, 1);
        check("writes_before_rst1", wcnt1, 1);
        wq0.delete(); wq1.delete(); dq0.delete(); dq1.delete();
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("writes_after_rst0", wcnt0, 1);
        check("rst_partial_mem", int'(mem0[601]), 0);
        run_job(4, 4, 1, 2, 2, 0, 0, 600);
        check_t1("t5", 600, 5, 7, 13, 15);

`ifdef POOL_AVG_EN
        run_job(4, 4, 1, 2, 2, 1, 0, 700);
        check_t1("t6", 700, 2, 4, 10, 12);
        run_job(4, 4, 1, 3, 1, 1, 0, 720);
`endif

        // randomized jobs, some wrapping the input region past the top of memory
        for (int t = 0; t < 30; t++) begin
            r = $urandom_range(1, 7);
            c = $urandom_range(1, 7);
            n = $urandom_range(1, 3);
            k = $urandom_range(1, 4);
            s = $urandom_range(1, 3);
            if ($urandom_range(0, 9) == 0) k = $urandom_range(0, 6);
            if ($urandom_range(0, 14) == 0) s = 0;
            if ($urandom_range(0, 14) == 0) n = 0;
            avg  = $urandom_range(0, 1);
            inb  = (t % 5 == 0) ? 8180 : $urandom_range(0, 2000);
            outb = $urandom_range(3000, 3500);
            for (int i = 0; i < n * r * c; i++) put(inb + i, $urandom_range(0, 255));
            run_job(r, c, n, k, s, avg, inb, outb);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: got no finish, required finish");
        $fatal(1);
    end

endmodule
